// File: rtl/display_scanner_if.sv
// display_scanner_if: load/ack handshake plus anode/segment drive bundle for display_scanner.
interface display_scanner_if #(parameter int DIGITS = 4);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                load_ack;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;
    modport master(output value, dp_in, load, input load_ack, an, seg, dp);
    modport slave(input value, dp_in, load, output load_ack, an, seg, dp);
endinterface

// File: rtl/display_scanner.sv
// display_scanner: multiplexed common-anode 7-segment driver with frame-aligned value commit.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
module display_scanner #(parameter int DIGITS = 4) (
    input  logic clk,
    input  logic rst_n,
    input  logic scan_clk_i,
    display_scanner_if.slave bus
);
    logic [2:0]          sync_q;
    logic [2:0]          idx_q;
    logic                pend_q, ack_q, dp_q;
    logic [4*DIGITS-1:0] pend_val_q, act_val_q;
    logic [DIGITS-1:0]   pend_dp_q, act_dp_q, an_q, an_d;
    logic [6:0]          seg_q, seg_d, dec;
    logic                dp_d, tick, wrap, commit, blank;
    logic [31:0]         val_x;
    logic [7:0]          dp_x;
    logic [3:0]          nib;
    assign tick   = sync_q[1] & ~sync_q[2];
    assign wrap   = idx_q == 3'(DIGITS - 1);
    assign commit = tick & wrap & pend_q;
    assign val_x  = 32'(act_val_q);
    assign dp_x   = 8'(act_dp_q);
    assign nib    = val_x[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    // current nibble and every nibble above it are zero
    assign blank  = (idx_q != 3'd0) && ((val_x >> {idx_q, 2'b00}) == 32'd0);
`else
    assign blank  = 1'b0;
`endif
    always_comb begin
        case (nib)
            4'h0: dec = 7'b1000000;
            4'h1: dec = 7'b1111001;
            4'h2: dec = 7'b0100100;
            4'h3: dec = 7'b0110000;
            4'h4: dec = 7'b0011001;
            4'h5: dec = 7'b0010010;
            4'h6: dec = 7'b0000010;
            4'h7: dec = 7'b1111000;
            4'h8: dec = 7'b0000000;
            4'h9: dec = 7'b0010000;
            4'hA: dec = 7'b0001000;
            4'hB: dec = 7'b0000011;
            4'hC: dec = 7'b1000110;
            4'hD: dec = 7'b0100001;
            4'hE: dec = 7'b0000110;
            default: dec = 7'b0001110;
        endcase
    end
    assign an_d  = blank ? '1 : ~(DIGITS'(1) << idx_q);
    assign seg_d = blank ? 7'h7f : dec;
    assign dp_d  = blank | ~dp_x[idx_q];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            an_q       <= '1;
            seg_q      <= 7'h7f;
            dp_q       <= 1'b1;
        end else begin
            sync_q <= {sync_q[1:0], scan_clk_i};
            if (tick) idx_q <= wrap ? 3'd0 : idx_q + 3'd1;
            ack_q <= commit;
            if (commit) begin
                act_val_q <= pend_val_q;
                act_dp_q  <= pend_dp_q;
            end
            // a load in the commit cycle lands in pend after the old contents moved out
            if (bus.load) begin
                pend_val_q <= bus.value;
                pend_dp_q  <= bus.dp_in;
            end
            pend_q <= bus.load | (pend_q & ~commit);
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end
    assign bus.load_ack = ack_q;
    assign bus.an       = an_q;
    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;
endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for the board's common-anode 7-segment display. It consumes the slow square wave from the display clock divider, steps through the digits one at a time, decodes each hex nibble to active-low segments and drives the anodes. New display values are accepted through a load/ack handshake and switched in only at frame boundaries, so a partially updated number is never shown.

## Interface

- DIGITS, 4, number of multiplexed digits (1..8); `value` width is 4*DIGITS.

- clk  input  1  system clock (100 MHz).
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- scan_clk  input  1  divided display clock (divider output `q`), treated as data and synchronized internally.
- value  input  4*DIGITS  hex nibbles; nibble i is shown on digit i (digit 0 = rightmost).
- dp_in  input  DIGITS  decimal-point request per digit, active-high.
- load  input  1  one-cycle strobe; captures `value`/`dp_in`.
- load_ack  output  1  one-cycle pulse when the captured value becomes visible.
- an  output  DIGITS  anode enables, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation

- Synchronizer: two flops on `scan_clk`, plus a third flop for edge detect; `tick` = synced & ~previous (rising edge only). Falling edges are ignored.
- Digit index `idx` (3 bits): +1 on `tick`, wraps DIGITS-1 -> 0. Frame boundary = a tick while idx == DIGITS-1.
- Registers: `pend_val`/`pend_dp` (written on `load`), `pend` flag, `act_val`/`act_dp` (displayed).
- On load: pend_val <= value, pend_dp <= dp_in, pend <= 1. A second load before commit overwrites (last wins); only one ack is issued.
- On a frame boundary with pend = 1: act <= pend registers, pend <= 0, load_ack = 1 for that cycle.
- Simultaneous load and commit in the same cycle: the commit uses the pend contents from before this cycle; the new load is written to pend and pend stays 1 (committed at the next frame).
- Decode (hex, full 0-F): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- an: bit idx low, all others high. dp = ~act_dp[idx].
- Reset (rst = 0, any time): idx = 0, pend = 0, act/pend registers = 0, synchronizer flops = 0, an = all 1, seg = 1111111, dp = 1, load_ack = 0. After release, an/seg/dp drive digit 0 from the next clock edge.

## Timing

- scan_clk rising edge -> tick: 3 clk edges (2 sync + 1 edge register).
- tick -> new an/seg/dp: 1 clk (outputs are registered from idx and act).
- load_ack asserts in the same cycle as the commit; act-based outputs change 1 clk later.
- With divider terminal count 99999, scan_clk period = 200000 clk, giving 2 ms per digit and an 8 ms frame (DIGITS = 4).
- Worst-case load-to-visible latency: DIGITS ticks + 4 clk.
- `load` is level-sampled every cycle. Holding it high for N cycles acts as N loads.

## Configuration

- LEADING_ZERO_BLANK_EN defined: any digit i > 0 whose nibble is 0 and all of whose higher nibbles are 0 is blanked (an held all-high, seg = 1111111, dp = 1 during its slot). Digit 0 is never blanked. idx timing is unchanged.
- Undefined: every digit is always driven, including leading zeros.

## Test plan

- Reset: hold rst = 0 and toggle scan_clk -> an = 1111, seg = 1111111, dp = 1, load_ack = 0 throughout.
- Scan: load 16'h1234 and run 8 scan_clk periods -> an cycles 1110,1101,1011,0111 with seg 0011001(4), 0110000(3), 0100100(2), 1111001(1); idx wraps to 0.
- Frame-boundary commit: act = 16'h1234; load 16'hABCD mid-frame -> 1234 is shown until digit 3's slot ends; load_ack pulses exactly once at the idx 3->0 tick; next frame shows D,C,b,A.
- Last-wins and simultaneous events: load 16'h1111 then 16'h2222 before the boundary -> one ack, 2222 shown. Load 16'h3333 on the commit cycle -> pend stays 1, second ack arrives one frame later.
- Decimal point and reset mid-frame: dp_in = 4'b0100 -> dp = 0 only in the an = 1011 slot. Pulse rst = 0 at idx = 2 -> outputs go to reset values immediately, then restart at digit 0 with act = 0.
- Leading zeros with LEADING_ZERO_BLANK_EN defined: load 16'h0050 -> digits 3 and 2 blanked, digit 1 = 5, digit 0 = 0. Load 16'h0000 -> only digit 0 lit (1000000).
